pht_update_sched: RTL and testbench

- Serialises branch-resolution updates from both execute lanes of the dual-issue pipeline onto the single write port of the gshare pattern history table.
- Queues updates in a small FIFO and drives the matching GHR shift.
- Owns the table initialisation sequence: every entry is walked to weakly-not-taken after reset or on request.
- Sits between the two execute stages and the PHT/GHR storage.

---
 rtl/pht_update_sched.sv | 119 +++++++++++
 tb/tb_pht_update_sched.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pht_update_sched.sv
// Branch-update scheduler: serialises dual-lane branch resolutions onto the single
// PHT write port, drives the GHR shift, and runs the weakly-not-taken table init.
module pht_update_sched #(
   parameter int IDX_W = 6,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             reinit,
   input  logic             br0_valid,
   input  logic [IDX_W-1:0] br0_pc,
   input  logic [IDX_W-1:0] br0_ghr,
   input  logic             br0_taken,
   input  logic             br1_valid,
   input  logic [IDX_W-1:0] br1_pc,
   input  logic [IDX_W-1:0] br1_ghr,
   input  logic             br1_taken,
   output logic             stall,
   output logic             init_busy,
   output logic             pht_we,
   output logic [IDX_W-1:0] pht_index,
   output logic [1:0]       pht_op,
   output logic             ghr_shift,
   output logic             ghr_bit
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t           state_q;
   logic [IDX_W-1:0] init_cnt_q;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr1_ptr;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_mem [DEPTH];
   logic             tkn_mem [DEPTH];
   logic             push0, push1, pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign init_busy = (state_q == S_INIT);
   // Depends only on registered occupancy: a free pair of slots is guaranteed when low.
   assign stall     = (state_q == S_INIT) || (cnt_q > CW'(DEPTH - 2));

   always_comb begin
      push0    = !reinit && !stall && br0_valid;
      push1    = !reinit && !stall && br1_valid;
      pop      = (state_q == S_RUN) && (cnt_q != '0);
      wr1_ptr  = push0 ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      wr_ptr_d = push1 ? ptr_inc(wr1_ptr) : wr1_ptr;
      rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      cnt_d    = cnt_q + CW'(push0) + CW'(push1) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (push0) begin
         idx_mem[wr_ptr_q] <= br0_pc ^ br0_ghr;
         tkn_mem[wr_ptr_q] <= br0_taken;
      end
      if (push1) begin
         idx_mem[wr1_ptr] <= br1_pc ^ br1_ghr;
         tkn_mem[wr1_ptr] <= br1_taken;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_INIT;
         init_cnt_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         pht_we     <= 1'b0;
         pht_index  <= '0;
         pht_op     <= 2'b00;
         ghr_shift  <= 1'b0;
         ghr_bit    <= 1'b0;
      end else if (reinit) begin
         state_q    <= S_INIT;
         init_cnt_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         pht_we     <= 1'b0;
         ghr_shift  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         case (state_q)
            S_INIT: begin
               pht_we     <= 1'b1;
               pht_op     <= 2'b10;
               pht_index  <= init_cnt_q;
               ghr_shift  <= 1'b0;
               init_cnt_q <= init_cnt_q + 1'b1;
               if (init_cnt_q == '1) state_q <= S_RUN;
            end
            S_RUN: begin
               if (pop) begin
                  pht_we    <= 1'b1;
                  pht_index <= idx_mem[rd_ptr_q];
                  pht_op    <= {1'b0, tkn_mem[rd_ptr_q]};
                  ghr_shift <= 1'b1;
                  ghr_bit   <= tkn_mem[rd_ptr_q];
               end else begin
                  pht_we    <= 1'b0;
                  ghr_shift <= 1'b0;
               end
            end
            default: state_q <= S_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_pht_update_sched.sv
// Randomised bench for pht_update_sched against a queue-based model of the
// update schedule, plus directed init, reinit and reset-during-init cases.
module tb_pht_update_sched;

   localparam int IDX_W = 6;
   localparam int DEPTH = 4;
   localparam int NENT  = 1 << IDX_W;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             reinit = 1'b0;
   logic             br0_valid = 1'b0, br0_taken = 1'b0;
   logic             br1_valid = 1'b0, br1_taken = 1'b0;
   logic [IDX_W-1:0] br0_pc = '0, br0_ghr = '0, br1_pc = '0, br1_ghr = '0;
   logic             stall, init_busy, pht_we, ghr_shift, ghr_bit;
   logic [IDX_W-1:0] pht_index;
   logic [1:0]       pht_op;

   pht_update_sched #(.IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .reinit(reinit),
      .br0_valid(br0_valid), .br0_pc(br0_pc), .br0_ghr(br0_ghr), .br0_taken(br0_taken),
      .br1_valid(br1_valid), .br1_pc(br1_pc), .br1_ghr(br1_ghr), .br1_taken(br1_taken),
      .stall(stall), .init_busy(init_busy), .pht_we(pht_we), .pht_index(pht_index),
      .pht_op(pht_op), .ghr_shift(ghr_shift), .ghr_bit(ghr_bit)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      assert (!(reset && stall && (br0_valid || br1_valid)))
         else $error("upstream presented a branch while stalled");

   typedef struct {
      logic [IDX_W-1:0] idx;
      logic             t;
   } ent_t;

   ent_t             q[$];
   bit               m_init;
   int               m_cnt;
   bit               e_we, e_sh, e_bit;
   logic [IDX_W-1:0] e_idx;
   logic [1:0]       e_op;
   int               n_checks = 0;
   int               n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_init = 1'b1;
      m_cnt  = 0;
      e_we   = 1'b0;
      e_sh   = 1'b0;
   endtask

   // One clock: drive at negedge, check stall, advance model, check strobe after the edge.
   task automatic step(input bit ri, input bit v0, input logic [IDX_W-1:0] p0, g0, input bit t0,
                       input bit v1, input logic [IDX_W-1:0] p1, g1, input bit t1);
      bit   ms;
      ent_t e;
      @(negedge clk);
      ms = m_init || (q.size() > DEPTH - 2);
      if (ms) begin
         v0 = 1'b0;
         v1 = 1'b0;
      end
      reinit = ri;
      br0_valid = v0; br0_pc = p0; br0_ghr = g0; br0_taken = t0;
      br1_valid = v1; br1_pc = p1; br1_ghr = g1; br1_taken = t1;
      check_eq("stall", stall, ms);
      check_eq("init_busy", init_busy, m_init);
      if (ri) begin
         q.delete();
         m_init = 1'b1;
         m_cnt  = 0;
         e_we   = 1'b0;
         e_sh   = 1'b0;
      end else if (m_init) begin
         e_we  = 1'b1;
         e_op  = 2'b10;
         e_idx = IDX_W'(m_cnt);
         e_sh  = 1'b0;
         m_cnt++;
         if (m_cnt == NENT) m_init = 1'b0;
      end else begin
         if (q.size() > 0) begin
            e     = q.pop_front();
            e_we  = 1'b1;
            e_idx = e.idx;
            e_op  = {1'b0, e.t};
            e_sh  = 1'b1;
            e_bit = e.t;
         end else begin
            e_we = 1'b0;
            e_sh = 1'b0;
         end
         if (v0) q.push_back('{p0 ^ g0, t0});
         if (v1) q.push_back('{p1 ^ g1, t1});
      end
      @(posedge clk);
      #1;
      check_eq("pht_we", pht_we, e_we);
      if (e_we) begin
         check_eq("pht_index", pht_index, e_idx);
         check_eq("pht_op", pht_op, e_op);
      end
      check_eq("ghr_shift", ghr_shift, e_sh);
      if (e_sh) check_eq("ghr_bit", ghr_bit, e_bit);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic rand_step(input int vpct, input int rpct);
      step(($urandom_range(0, 99) < rpct),
           ($urandom_range(0, 99) < vpct), IDX_W'($urandom), IDX_W'($urandom), 1'($urandom),
           ($urandom_range(0, 99) < vpct), IDX_W'($urandom), IDX_W'($urandom), 1'($urandom));
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_we"}, pht_we, 1'b0);
      check_eq({tag, "_idx"}, pht_index, '0);
      check_eq({tag, "_op"}, pht_op, 2'b00);
      check_eq({tag, "_shift"}, ghr_shift, 1'b0);
      check_eq({tag, "_bit"}, ghr_bit, 1'b0);
      check_eq({tag, "_busy"}, init_busy, 1'b1);
      check_eq({tag, "_stall"}, stall, 1'b1);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      check_reset_outputs("rst");
      reset = 1'b1;

      // Init walk: 64 consecutive weakly-not-taken writes.
      for (int i = 0; i < NENT; i++) begin
         idle();
         check_eq("t1_idx", pht_index, i);
      end
      idle();
      check_eq("t1_done_we", pht_we, 1'b0);

      // Single lane-0 update.
      step(1'b0, 1'b1, 6'h2A, 6'h0F, 1'b1, 1'b0, '0, '0, 1'b0);
      idle();
      check_eq("t2_idx", pht_index, 6'h25);
      check_eq("t2_op", pht_op, 2'b01);
      check_eq("t2_bit", ghr_bit, 1'b1);
      idle();
      check_eq("t2_idle", pht_we, 1'b0);

      // Both lanes in one cycle: lane 0 drains first.
      step(1'b0, 1'b1, 6'd3, 6'd0, 1'b0, 1'b1, 6'd5, 6'd1, 1'b1);
      idle();
      check_eq("t3_idx0", pht_index, 6'd3);
      check_eq("t3_op0", pht_op, 2'b00);
      idle();
      check_eq("t3_idx1", pht_index, 6'd4);
      check_eq("t3_op1", pht_op, 2'b01);
      idle();

      // Saturating dual pushes, then mixed random traffic with occasional reinit.
      for (int i = 0; i < 24; i++) rand_step(100, 0);
      for (int i = 0; i < 8; i++) idle();
      for (int i = 0; i < 400; i++) rand_step(60, 1);
      for (int i = 0; i < 80; i++) idle();

      // Reinit with a full FIFO: queued updates are discarded.
      step(1'b0, 1'b1, 6'd7, 6'd1, 1'b1, 1'b1, 6'd9, 6'd2, 1'b0);
      step(1'b0, 1'b1, 6'd11, 6'd3, 1'b1, 1'b1, 6'd13, 6'd4, 1'b0);
      check_eq("t5_full", stall, 1'b1);
      step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
      for (int i = 0; i < NENT + 4; i++) idle();
      for (int i = 0; i < 40; i++) rand_step(50, 0);

      // Reset in the middle of the init walk.
      step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
      for (int i = 0; i < NENT && !(m_init && e_we && e_idx == 6'd20); i++) idle();
      check_eq("t6_at20", pht_index, 6'd20);
      #2;
      reset = 1'b0;
      #1;
      check_reset_outputs("t6_rst");
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      check_reset_outputs("t6_hold");
      reset = 1'b1;
      for (int i = 0; i < NENT; i++) begin
         idle();
         check_eq("t6_idx", pht_index, i);
      end
      for (int i = 0; i < 60; i++) rand_step(70, 0);
      for (int i = 0; i < 10; i++) idle();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
